phys_regfile: RTL and testbench
===============================

PHYS_REGFILE -- requirements
Module: phys_regfile

Interface
REQ-001 Parameter DATA_WIDTH, default 32, bit width of each register.
REQ-002 Parameter NUM_REGS, default 64, number of physical registers (power of two, >= 4).
REQ-003 Parameter ADDR_WIDTH, default $clog2(NUM_REGS), register index width.
REQ-004 Parameter READ_PORTS, default 4, number of read ports.
REQ-005 Parameter WRITE_PORTS, default 2, number of writeback ports.
REQ-006 Parameter ALLOC_PORTS, default 2, number of allocation (mark-busy) ports.
REQ-007 Port clk  input  1  clock; all state updates on its rising edge.
REQ-008 Port rst  input  1  reset, synchronous, active-high.
REQ-009 Port rd_addr  input  READ_PORTS*ADDR_WIDTH  read indices; port i at [i*ADDR_WIDTH +: ADDR_WIDTH] (same slicing for all flattened buses).
REQ-010 Port rd_data  output  READ_PORTS*DATA_WIDTH  read data per port.
REQ-011 Port rd_ready  output  READ_PORTS  ready bit of the addressed register per port.
REQ-012 Port wr_en  input  WRITE_PORTS  writeback valid per port.
REQ-013 Port wr_addr  input  WRITE_PORTS*ADDR_WIDTH  writeback indices.
REQ-014 Port wr_data  input  WRITE_PORTS*DATA_WIDTH  writeback data.
REQ-015 Port alloc_en  input  ALLOC_PORTS  allocation valid per port.
REQ-016 Port alloc_addr  input  ALLOC_PORTS*ADDR_WIDTH  registers to mark not-ready.
REQ-017 Port wr_conflict  output  1  registered flag: previous cycle had two enabled write ports to the same nonzero index.

Function
REQ-018 Storage: NUM_REGS data registers plus one ready bit per register.
REQ-019 Register 0: reads return data 0 and ready 1 always; writes and allocations to index 0 ignored.
REQ-020 Writeback: wr_en[i] with nonzero wr_addr[i] stores wr_data[i] and sets ready at the next rising edge.
REQ-021 Write collision: multiple enabled write ports to same index -> highest-numbered port's data stored; wr_conflict asserted for exactly the following cycle.
REQ-022 Allocation: alloc_en[j] with nonzero index clears that register's ready bit at the next edge; data unchanged.
REQ-023 Alloc and writeback to same index in same cycle: data written, ready bit ends 0 (allocation wins).
REQ-024 Reads combinational; rd_data/rd_ready reflect stored state, modified per REQ-032 when bypass is compiled in.
REQ-025 Out-of-range index (NUM_REGS not power of two excluded by REQ-002) cannot occur; no range checks required.
REQ-026 Allocation never bypassed: same-cycle alloc does not affect that cycle's rd_ready.
REQ-027 Ports of each kind processed independently; no limit on simultaneous events beyond REQ-021/023.

Reset
REQ-028 rst sampled at rising edge; overrides all write and alloc activity that cycle.
REQ-029 After reset: all data 0, all ready bits 1, wr_conflict 0.
REQ-030 During reset cycle rd_data/rd_ready reflect pre-reset stored state (no bypass of reset).

Configuration
REQ-031 Macro PHYS_REGFILE_BYPASS_EN selects write-to-read forwarding.
REQ-032 Defined: a read whose index matches an enabled nonzero write port in the same cycle returns that port's wr_data (highest-numbered match) and rd_ready 1.
REQ-033 Undefined: no forwarding; written data and ready visible one cycle after the write edge.

Verification
REQ-034 Reset, read all 64 indices -> every rd_data 0, rd_ready 1.
REQ-035 Write 0xDEADBEEF to reg 5 port 0, read reg 5 next cycle -> 0xDEADBEEF, ready 1; write 0x1234 to reg 0 -> reg 0 reads 0.
REQ-036 Alloc reg 7, next cycle read -> ready 0; write 0xA5 to reg 7 -> next cycle ready 1, data 0xA5.
REQ-037 Ports 0 and 1 both write reg 9 (0x11, 0x22) -> reg 9 reads 0x22; wr_conflict 1 for one cycle then 0.
REQ-038 Same cycle alloc and write reg 12 with 0x55 -> next cycle data 0x55, ready 0.
REQ-039 With PHYS_REGFILE_BYPASS_EN: write 0x77 to reg 3 while reading reg 3 -> same-cycle rd_data 0x77, ready 1; without macro -> old value same cycle, 0x77 next cycle.

Source files
------------

// File: rtl/phys_regfile.sv
// Physical register file with per-register ready bits, multi-port writeback and allocation.
// Define PHYS_REGFILE_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module phys_regfile #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 64,
  parameter int ADDR_WIDTH  = $clog2(NUM_REGS),
  parameter int READ_PORTS  = 4,
  parameter int WRITE_PORTS = 2,
  parameter int ALLOC_PORTS = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0]  rd_addr,
  output logic [READ_PORTS*DATA_WIDTH-1:0]  rd_data,
  output logic [READ_PORTS-1:0]             rd_ready,
  input  logic [WRITE_PORTS-1:0]            wr_en,
  input  logic [WRITE_PORTS*ADDR_WIDTH-1:0] wr_addr,
  input  logic [WRITE_PORTS*DATA_WIDTH-1:0] wr_data,
  input  logic [ALLOC_PORTS-1:0]            alloc_en,
  input  logic [ALLOC_PORTS*ADDR_WIDTH-1:0] alloc_addr,
  output logic                              wr_conflict
);

  logic [DATA_WIDTH-1:0] data_q [NUM_REGS];
  logic [NUM_REGS-1:0]   ready_q;
  logic                  conflict_q;
  logic                  conflict_d;

  logic [ADDR_WIDTH-1:0] rd_idx  [READ_PORTS];
  logic [DATA_WIDTH-1:0] rd_val  [READ_PORTS];
  logic                  rd_rdy  [READ_PORTS];
  logic [ADDR_WIDTH-1:0] wr_idx  [WRITE_PORTS];
  logic [DATA_WIDTH-1:0] wr_val  [WRITE_PORTS];
  logic [ADDR_WIDTH-1:0] al_idx  [ALLOC_PORTS];

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    assign rd_idx[p] = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = rd_val[p];
    assign rd_ready[p] = rd_rdy[p];
  end

  for (genvar w = 0; w < WRITE_PORTS; w++) begin : g_wr
    assign wr_idx[w] = wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH];
    assign wr_val[w] = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
  end

  for (genvar a = 0; a < ALLOC_PORTS; a++) begin : g_al
    assign al_idx[a] = alloc_addr[a*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Later ports overwrite earlier ones so the highest-numbered writer wins;
  // allocations are applied last so they win the ready bit over writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        data_q[r] <= '0;
      end
      ready_q <= '1;
    end else begin
      for (int w = 0; w < WRITE_PORTS; w++) begin
        if (wr_en[w] && (wr_idx[w] != '0)) begin
          data_q[wr_idx[w]]  <= wr_val[w];
          ready_q[wr_idx[w]] <= 1'b1;
        end
      end
      for (int a = 0; a < ALLOC_PORTS; a++) begin
        if (alloc_en[a] && (al_idx[a] != '0)) begin
          ready_q[al_idx[a]] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    conflict_d = 1'b0;
    for (int i = 0; i < WRITE_PORTS; i++) begin
      for (int j = i + 1; j < WRITE_PORTS; j++) begin
        if (wr_en[i] && wr_en[j] && (wr_idx[i] == wr_idx[j]) && (wr_idx[i] != '0)) begin
          conflict_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign wr_conflict = conflict_q;

  // Register 0 is hardwired; forwarding (when built in) is suppressed while reset is asserted.
  always_comb begin
    for (int p = 0; p < READ_PORTS; p++) begin
      rd_val[p] = data_q[rd_idx[p]];
      rd_rdy[p] = ready_q[rd_idx[p]];
`ifdef PHYS_REGFILE_BYPASS_EN
      if (!rst) begin
        for (int w = 0; w < WRITE_PORTS; w++) begin
          if (wr_en[w] && (wr_idx[w] != '0) && (wr_idx[w] == rd_idx[p])) begin
            rd_val[p] = wr_val[w];
            rd_rdy[p] = 1'b1;
          end
        end
      end
`else
`endif
      if (rd_idx[p] == '0) begin
        rd_val[p] = '0;
        rd_rdy[p] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_phys_regfile.sv
// Directed self-checking bench for phys_regfile at default parameters.
// Expectations for same-cycle forwarding follow PHYS_REGFILE_BYPASS_EN.
module tb_phys_regfile;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NR = 64;
  localparam int RP = 4;
  localparam int WP = 2;
  localparam int AP = 2;

  logic              clk;
  logic              rst;
  logic [RP*AW-1:0]  rd_addr;
  logic [RP*DW-1:0]  rd_data;
  logic [RP-1:0]     rd_ready;
  logic [WP-1:0]     wr_en;
  logic [WP*AW-1:0]  wr_addr;
  logic [WP*DW-1:0]  wr_data;
  logic [AP-1:0]     alloc_en;
  logic [AP*AW-1:0]  alloc_addr;
  logic              wr_conflict;

  int checks;
  int failures;

  phys_regfile dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .wr_conflict(wr_conflict)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] rdat(input int p);
    return rd_data[p*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic set_al(input int p, input logic [AW-1:0] a);
    alloc_en[p] = 1'b1;
    alloc_addr[p*AW +: AW] = a;
  endtask

  task automatic idle();
    wr_en = '0;
    alloc_en = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (wr_conflict !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_conflict got=%b want=0", wr_conflict);
    end
    for (int base = 0; base < NR; base += RP) begin
      for (int p = 0; p < RP; p++) set_rd(p, AW'(base + p));
      #1;
      for (int p = 0; p < RP; p++) begin
        checks++;
        if (rdat(p) !== 32'h0 || rd_ready[p] !== 1'b1) begin
          failures++;
          $display("[TB] FAIL reset_read reg=%0d got=%h/%b want=00000000/1", base + p, rdat(p), rd_ready[p]);
        end
      end
    end
  endtask

  task automatic test_write();
    set_wr(0, 6'd5, 32'hDEADBEEF);
    tick();
    idle();
    set_rd(0, 6'd5);
    set_rd(1, 6'd0);
    #1;
    checks++;
    if (rdat(0) !== 32'hDEADBEEF || rd_ready[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL write_reg5 got=%h/%b want=deadbeef/1", rdat(0), rd_ready[0]);
    end
    set_wr(0, 6'd0, 32'h1234);
    tick();
    idle();
    #1;
    checks++;
    if (rdat(1) !== 32'h0 || rd_ready[1] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL write_reg0 got=%h/%b want=00000000/1", rdat(1), rd_ready[1]);
    end
  endtask

  task automatic test_alloc();
    set_al(0, 6'd7);
    set_al(1, 6'd0);
    tick();
    idle();
    set_rd(0, 6'd7);
    set_rd(1, 6'd0);
    #1;
    checks++;
    if (rd_ready[0] !== 1'b0 || rdat(0) !== 32'h0) begin
      failures++;
      $display("[TB] FAIL alloc_reg7 got=%h/%b want=00000000/0", rdat(0), rd_ready[0]);
    end
    checks++;
    if (rd_ready[1] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL alloc_reg0 got=%b want=1", rd_ready[1]);
    end
    set_wr(1, 6'd7, 32'hA5);
    tick();
    idle();
    #1;
    checks++;
    if (rdat(0) !== 32'hA5 || rd_ready[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL alloc_then_write got=%h/%b want=000000a5/1", rdat(0), rd_ready[0]);
    end
  endtask

  task automatic test_conflict();
    set_wr(0, 6'd9, 32'h11);
    set_wr(1, 6'd9, 32'h22);
    tick();
    idle();
    set_rd(0, 6'd9);
    #1;
    checks++;
    if (rdat(0) !== 32'h22) begin
      failures++;
      $display("[TB] FAIL conflict_data got=%h want=00000022", rdat(0));
    end
    checks++;
    if (wr_conflict !== 1'b1) begin
      failures++;
      $display("[TB] FAIL conflict_flag_set got=%b want=1", wr_conflict);
    end
    tick();
    checks++;
    if (wr_conflict !== 1'b0) begin
      failures++;
      $display("[TB] FAIL conflict_flag_clear got=%b want=0", wr_conflict);
    end
    // Both ports to register 0 and to distinct registers raise no conflict.
    set_wr(0, 6'd0, 32'h33);
    set_wr(1, 6'd0, 32'h44);
    tick();
    checks++;
    if (wr_conflict !== 1'b0) begin
      failures++;
      $display("[TB] FAIL conflict_reg0 got=%b want=0", wr_conflict);
    end
    set_wr(0, 6'd10, 32'hAAAA0010);
    set_wr(1, 6'd11, 32'hBBBB0011);
    tick();
    idle();
    set_rd(0, 6'd10);
    set_rd(1, 6'd11);
    #1;
    checks++;
    if (wr_conflict !== 1'b0 || rdat(0) !== 32'hAAAA0010 || rdat(1) !== 32'hBBBB0011) begin
      failures++;
      $display("[TB] FAIL dual_write got=%b/%h/%h want=0/aaaa0010/bbbb0011", wr_conflict, rdat(0), rdat(1));
    end
  endtask

  task automatic test_alloc_write();
    set_al(1, 6'd12);
    set_wr(0, 6'd12, 32'h55);
    set_rd(2, 6'd12);
    #1;
    checks++;
    if (rd_ready[2] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL alloc_not_bypassed got=%b want=1", rd_ready[2]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rdat(2) !== 32'h55 || rd_ready[2] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL alloc_write_same got=%h/%b want=00000055/0", rdat(2), rd_ready[2]);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] exp_now;
    set_rd(2, 6'd3);
    set_wr(0, 6'd3, 32'h77);
    #1;
`ifdef PHYS_REGFILE_BYPASS_EN
    exp_now = 32'h77;
`else
    exp_now = 32'h0;
`endif
    checks++;
    if (rdat(2) !== exp_now || rd_ready[2] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bypass_same_cycle got=%h/%b want=%h/1", rdat(2), rd_ready[2], exp_now);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rdat(2) !== 32'h77 || rd_ready[2] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bypass_next_cycle got=%h/%b want=00000077/1", rdat(2), rd_ready[2]);
    end
  endtask

  task automatic test_reset_override();
    rst = 1'b1;
    set_wr(0, 6'd30, 32'h99);
    set_wr(1, 6'd30, 32'h98);
    set_al(0, 6'd21);
    set_rd(0, 6'd5);
    set_rd(1, 6'd30);
    set_rd(2, 6'd12);
    #1;
    checks++;
    if (rdat(0) !== 32'hDEADBEEF || rdat(1) !== 32'h0 || rd_ready[2] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_cycle_read got=%h/%h/%b want=deadbeef/00000000/0", rdat(0), rdat(1), rd_ready[2]);
    end
    tick();
    rst = 1'b0;
    idle();
    set_rd(3, 6'd21);
    #1;
    checks++;
    if (wr_conflict !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_conflict_override got=%b want=0", wr_conflict);
    end
    checks++;
    if (rdat(0) !== 32'h0 || rdat(1) !== 32'h0 || rdat(2) !== 32'h0 ||
        rd_ready !== 4'b1111) begin
      failures++;
      $display("[TB] FAIL reset_override got=%h/%h/%h/%b want=0/0/0/1111", rdat(0), rdat(1), rdat(2), rd_ready);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    rd_addr = '0;
    wr_en = '0;
    wr_addr = '0;
    wr_data = '0;
    alloc_en = '0;
    alloc_addr = '0;
    #2;
    test_reset();
    test_write();
    test_alloc();
    test_conflict();
    test_alloc_write();
    test_bypass();
    test_reset_override();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
